// File: rtl/divider_result_buffer.sv
// Result collector for the restoring-divider cell chain: a show-ahead FIFO
// that captures non-stallable results and grants launch credits by occupancy.
module divider_result_buffer #(
  parameter int QW    = 8,
  parameter int RW    = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     issue,
  output logic                     credit_ok,
  input  logic                     res_rdy,
  input  logic [QW-1:0]            res_quot,
  input  logic [RW-1:0]            res_rem,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [QW-1:0]            out_quot,
  output logic [RW-1:0]            out_rem,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_ovf,
  output logic                     err_credit
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = AW + 2;
  localparam int EW = QW + RW;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [IW-1:0] inflight;
  logic [EW-1:0] head;
  logic [IW:0]   occupancy;
  logic          push;
  logic          pop;

  // Saturating up/down step for the in-flight counter.
  function automatic logic [IW-1:0] sat_inflight(input logic [IW-1:0] cur,
                                                 input logic inc,
                                                 input logic dec);
    logic [IW-1:0] nxt;
    nxt = cur;
    if (inc && !dec && (cur != {IW{1'b1}})) nxt = cur + IW'(1);
    if (dec && !inc && (cur != '0))          nxt = cur - IW'(1);
    return nxt;
  endfunction

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign push      = res_rdy && ((count < CW'(DEPTH)) || pop);

  // Credit looks only at registered state so a same-cycle pop never frees a slot early.
  assign occupancy = {1'b0, IW'(count)} + {1'b0, inflight};
  assign credit_ok = (occupancy < (IW+1)'(DEPTH));

  assign head     = mem[rd_ptr];
  assign out_quot = out_valid ? head[EW-1:RW] : '0;
  assign out_rem  = out_valid ? head[RW-1:0]  : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {res_quot, res_rem};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      inflight   <= '0;
      err_ovf    <= 1'b0;
      err_credit <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      inflight <= sat_inflight(inflight, issue, res_rdy);
      if (res_rdy && !push)      err_ovf    <= 1'b1;
      if (issue && !credit_ok)   err_credit <= 1'b1;
    end
  end

endmodule

// File: tb/tb_divider_result_buffer.sv
// Directed and model-based bench for divider_result_buffer (QW=8, RW=4, DEPTH=4).
module tb_divider_result_buffer;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       issue = 1'b0;
  logic       credit_ok;
  logic       res_rdy = 1'b0;
  logic [7:0] res_quot = '0;
  logic [3:0] res_rem = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_quot;
  logic [3:0] out_rem;
  logic [2:0] count;
  logic       err_ovf;
  logic       err_credit;

  int n_tests = 0;
  int n_fail  = 0;

  divider_result_buffer #(.QW(8), .RW(4), .DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .issue(issue), .credit_ok(credit_ok),
    .res_rdy(res_rdy), .res_quot(res_quot), .res_rem(res_rem),
    .out_valid(out_valid), .out_ready(out_ready), .out_quot(out_quot),
    .out_rem(out_rem), .count(count), .err_ovf(err_ovf), .err_credit(err_credit)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rstn = 1'b0;
    #2;
    n_tests++;
    if (err_ovf !== 1'b0 || err_credit !== 1'b0 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_pulse got ovf=%b cred=%b count=%0d exp 0 0 0", err_ovf, err_credit, count);
    end
    rstn = 1'b1;
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < 4; i++) begin
      res_rdy = 1'b1; res_quot = base + 8'(i); res_rem = 4'(i);
      step();
    end
    res_rdy = 1'b0;
  endtask

  task automatic test_reset();
    res_rdy = 1'b1; res_quot = 8'h55; res_rem = 4'h5;
    rstn = 1'b0;
    repeat (2) step();
    n_tests++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_quot !== 8'h00 || out_rem !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_state got count=%0d v=%b q=%h r=%h exp 0 0 00 0", count, out_valid, out_quot, out_rem);
    end
    n_tests++;
    if (credit_ok !== 1'b1 || err_ovf !== 1'b0 || err_credit !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags got credit=%b ovf=%b cred=%b exp 1 0 0", credit_ok, err_ovf, err_credit);
    end
    res_rdy = 1'b0;
    rstn = 1'b1;
    step();
    res_rdy = 1'b1; res_quot = 8'h2A; res_rem = 4'h3;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL no_bypass got out_valid=%b exp 0", out_valid);
    end
    step();
    res_rdy = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || out_quot !== 8'h2A || out_rem !== 4'h3 || count !== 3'd1) begin
      n_fail++;
      $display("FAIL first_result got v=%b q=%h r=%h count=%0d exp 1 2a 3 1", out_valid, out_quot, out_rem, count);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || out_quot !== 8'h00 || out_rem !== 4'h0 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL empty_gating got v=%b q=%h r=%h count=%0d exp 0 00 0 0", out_valid, out_quot, out_rem, count);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_tests++;
    if (count !== 3'd0) begin
      n_fail++;
      $display("FAIL ready_when_empty got count=%0d exp 0", count);
    end
  endtask

  task automatic test_credit();
    bit is_iss, is_res;
    out_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      is_iss = (c == 0 || c == 2 || c == 4 || c == 6);
      is_res = (c == 5 || c == 7 || c == 9 || c == 11);
      if (is_iss) begin
        n_tests++;
        if (credit_ok !== 1'b1) begin
          n_fail++;
          $display("FAIL credit_before_issue cycle=%0d got %b exp 1", c, credit_ok);
        end
      end
      issue = is_iss;
      res_rdy = is_res;
      res_quot = is_res ? 8'((c - 5) / 2 + 1) : 8'h00;
      res_rem = 4'h1;
      step();
      if (c == 6) begin
        n_tests++;
        if (credit_ok !== 1'b0) begin
          n_fail++;
          $display("FAIL credit_after_4th got %b exp 0", credit_ok);
        end
      end
    end
    issue = 1'b0; res_rdy = 1'b0;
    n_tests++;
    if (count !== 3'd4 || credit_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL credit_full got count=%0d credit=%b exp 4 0", count, credit_ok);
    end
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_quot !== 8'(i)) begin
        n_fail++;
        $display("FAIL drain_order idx=%0d got v=%b q=%h exp 1 %h", i, out_valid, out_quot, 8'(i));
      end
      if (i == 1) begin
        n_tests++;
        if (credit_ok !== 1'b0) begin
          n_fail++;
          $display("FAIL credit_same_cycle_pop got %b exp 0", credit_ok);
        end
      end
      step();
      if (i == 1) begin
        n_tests++;
        if (credit_ok !== 1'b1) begin
          n_fail++;
          $display("FAIL credit_after_pop got %b exp 1", credit_ok);
        end
      end
    end
    out_ready = 1'b0;
    n_tests++;
    if (count !== 3'd0) begin
      n_fail++;
      $display("FAIL drain_empty got count=%0d exp 0", count);
    end
  endtask

  task automatic test_full_push_pop();
    fill(8'h10);
    res_rdy = 1'b1; res_quot = 8'h14; res_rem = 4'hA;
    out_ready = 1'b1;
    step();
    res_rdy = 1'b0;
    out_ready = 1'b0;
    n_tests++;
    if (count !== 3'd4 || out_quot !== 8'h11 || err_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL full_push_pop got count=%0d q=%h ovf=%b exp 4 11 0", count, out_quot, err_ovf);
    end
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      n_tests++;
      if (out_quot !== 8'h10 + 8'(i) || out_rem !== ((i == 4) ? 4'hA : 4'(i))) begin
        n_fail++;
        $display("FAIL full_tail idx=%0d got q=%h r=%h exp %h %h", i, out_quot, out_rem,
                 8'h10 + 8'(i), (i == 4) ? 4'hA : 4'(i));
      end
      step();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    fill(8'h20);
    res_rdy = 1'b1; res_quot = 8'hFF; res_rem = 4'hF;
    step();
    res_rdy = 1'b0;
    n_tests++;
    if (count !== 3'd4 || err_ovf !== 1'b1 || out_quot !== 8'h20) begin
      n_fail++;
      $display("FAIL overflow got count=%0d ovf=%b q=%h exp 4 1 20", count, err_ovf, out_quot);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (out_quot !== 8'h20 + 8'(i)) begin
        n_fail++;
        $display("FAIL overflow_contents idx=%0d got %h exp %h", i, out_quot, 8'h20 + 8'(i));
      end
      step();
    end
    out_ready = 1'b0;
    step();
    n_tests++;
    if (count !== 3'd0 || err_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_sticky got count=%0d ovf=%b exp 0 1", count, err_ovf);
    end
    pulse_reset();
  endtask

  task automatic test_credit_err();
    logic exp_credit [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      issue = 1'b1;
      step();
    end
    n_tests++;
    if (credit_ok !== 1'b0 || err_credit !== 1'b0) begin
      n_fail++;
      $display("FAIL credit_exhausted got credit=%b err=%b exp 0 0", credit_ok, err_credit);
    end
    issue = 1'b1;
    #1;
    n_tests++;
    if (credit_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL credit_comb_path got %b exp 0", credit_ok);
    end
    step();
    issue = 1'b0;
    n_tests++;
    if (err_credit !== 1'b1) begin
      n_fail++;
      $display("FAIL err_credit_set got %b exp 1", err_credit);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      res_rdy = 1'b1; res_quot = 8'h40 + 8'(i); res_rem = 4'h2;
      step();
      n_tests++;
      if (credit_ok !== exp_credit[i]) begin
        n_fail++;
        $display("FAIL credit_return idx=%0d got %b exp %b", i, credit_ok, exp_credit[i]);
      end
    end
    res_rdy = 1'b0;
    step();
    out_ready = 1'b0;
    n_tests++;
    if (count !== 3'd0 || err_credit !== 1'b1 || err_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL credit_err_final got count=%0d cred=%b ovf=%b exp 0 1 0", count, err_credit, err_ovf);
    end
    pulse_reset();
  endtask

  task automatic test_random();
    localparam int LAT = 5;
    logic        pv [LAT];
    logic [7:0]  pq [LAT];
    logic [3:0]  pr [LAT];
    logic [11:0] sb [$];
    logic [11:0] exp_e;
    logic [7:0]  a;
    logic [3:0]  d;
    int launched = 0;
    int received = 0;
    int cycles = 0;
    for (int i = 0; i < LAT; i++) begin pv[i] = 1'b0; pq[i] = '0; pr[i] = '0; end
    out_ready = 1'b1;
    while (received < 200 && cycles < 3000) begin
      issue = credit_ok && (launched < 200);
      res_rdy = pv[LAT-1]; res_quot = pq[LAT-1]; res_rem = pr[LAT-1];
      if (out_valid) begin
        exp_e = (sb.size() != 0) ? sb.pop_front() : 12'hxxx;
        n_tests++;
        if ({out_quot, out_rem} !== exp_e) begin
          n_fail++;
          $display("FAIL random_result idx=%0d got %h exp %h", received, {out_quot, out_rem}, exp_e);
        end
        received++;
      end
      if (res_rdy) sb.push_back({res_quot, res_rem});
      step();
      cycles++;
      for (int i = LAT - 1; i > 0; i--) begin
        pv[i] = pv[i-1]; pq[i] = pq[i-1]; pr[i] = pr[i-1];
      end
      pv[0] = issue;
      if (issue) begin
        a = 8'($urandom_range(0, 255));
        d = 4'($urandom_range(1, 15));
        pq[0] = a / {4'h0, d};
        pr[0] = 4'(a % {4'h0, d});
        launched++;
      end
    end
    issue = 1'b0; res_rdy = 1'b0; out_ready = 1'b0;
    n_tests++;
    if (received !== 200 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL random_count got %0d left=%0d exp 200 0", received, sb.size());
    end
    n_tests++;
    if (err_ovf !== 1'b0 || err_credit !== 1'b0 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL random_flags got ovf=%b cred=%b count=%0d exp 0 0 0", err_ovf, err_credit, count);
    end
  endtask

  initial begin
    test_reset();
    test_credit();
    test_full_push_pop();
    test_overflow();
    test_credit_err();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
